// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: load-extract modes, HI/LO read selects and the
// default link register index.
package pipeline_pkg;

  typedef enum logic [1:0] {
    EXTR_WORD  = 2'd0,
    EXTR_BYTE  = 2'd1,
    EXTR_HALF  = 2'd2,
    EXTR_MERGE = 2'd3
  } extr_e;

  typedef enum logic [1:0] {
    LH_NONE = 2'd0,
    LH_LO   = 2'd1,
    LH_HI   = 2'd2,
    LH_BAD  = 2'd3
  } lh_e;

  localparam int RA_IDX_DEFAULT = 31;

endpackage

// File: rtl/wb_stage_if.sv
// Writeback stage bus: incoming beat fields plus the registered regfile write
// and architectural HI/LO.
interface wb_stage_if #(
  parameter int DATA_BITS = 32
);
  localparam int AB = $clog2(DATA_BITS / 8);

  // Handshake: in_valid marks a beat and there is no ready. stall freezes the
  // whole stage, flush kills the incoming beat (flush wins over stall), and a
  // beat is taken on an edge where in_valid & ~stall & ~flush.
  logic                 in_valid;
  logic                 stall;
  logic                 flush;
  logic [4:0]           rt;
  logic [4:0]           rd;
  logic                 reg_dst;
  logic                 jal;
  logic                 link;
  logic                 mem_to_reg;
  logic                 extr_signed;
  pipeline_pkg::extr_e  extr_word;
  pipeline_pkg::lh_e    lh_to_reg;
  logic [DATA_BITS-1:0] alu_out;
  logic [DATA_BITS-1:0] mem_out;
  logic [DATA_BITS-1:0] pc;
  logic [DATA_BITS-1:0] rt_val;
  logic [AB-1:0]        addr_byte;
  logic                 merge_left;
  logic [1:0]           hilo_we;
  logic [DATA_BITS-1:0] hi_in;
  logic [DATA_BITS-1:0] lo_in;

  logic                 wb_valid;
  logic [4:0]           wb_idx;
  logic [DATA_BITS-1:0] wb_data;
  logic [DATA_BITS-1:0] hi;
  logic [DATA_BITS-1:0] lo;

  modport master (
    output in_valid, stall, flush, rt, rd, reg_dst, jal, link, mem_to_reg,
           extr_signed, extr_word, lh_to_reg, alu_out, mem_out, pc, rt_val,
           addr_byte, merge_left, hilo_we, hi_in, lo_in,
    input  wb_valid, wb_idx, wb_data, hi, lo
  );

  modport slave (
    input  in_valid, stall, flush, rt, rd, reg_dst, jal, link, mem_to_reg,
           extr_signed, extr_word, lh_to_reg, alu_out, mem_out, pc, rt_val,
           addr_byte, merge_left, hilo_we, hi_in, lo_in,
    output wb_valid, wb_idx, wb_data, hi, lo
  );

endinterface

// File: rtl/load_extract.sv
// Combinational load formatter: byte/halfword/word extraction with optional
// sign extension, and LWL/LWR merging when WB_UNALIGNED_EN is defined.
module load_extract
  import pipeline_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  extr_e                          extr_word,
  input  logic                           extr_signed,
  input  logic [$clog2(DATA_BITS/8)-1:0] addr_byte,
  input  logic [DATA_BITS-1:0]           mem_out,
  input  logic [DATA_BITS-1:0]           rt_val,
  input  logic                           merge_left,
  output logic [DATA_BITS-1:0]           load_data
);

  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic [DATA_BITS-1:0] word_v;
  logic [DATA_BITS-1:0] merge_v;

  assign byte_v = mem_out[{addr_byte, 3'b000} +: 8];
  assign half_v = mem_out[{addr_byte[1], 4'b0000} +: 16];

  // On a 64-bit datapath a "word" is the 32-bit half picked by addr_byte[2].
  if (DATA_BITS == 64) begin : g_word64
    logic [31:0] w32;
    assign w32    = mem_out[{addr_byte[2], 5'b00000} +: 32];
    assign word_v = {{(DATA_BITS-32){extr_signed & w32[31]}}, w32};
  end else begin : g_word32
    assign word_v = mem_out;
  end

`ifdef WB_UNALIGNED_EN
  // Big-endian: LWL shifts memory up into the high bytes, LWR shifts it down
  // into the low bytes; bytes not covered keep the old rt contents.
  logic [DATA_BITS-1:0]           ones;
  logic [$clog2(DATA_BITS/8)-1:0] rbyte;
  assign ones    = '1;
  assign rbyte   = ~addr_byte;
  assign merge_v = merge_left
    ? ((mem_out << {addr_byte, 3'b000}) | (rt_val & ~(ones << {addr_byte, 3'b000})))
    : ((mem_out >> {rbyte, 3'b000})     | (rt_val & ~(ones >> {rbyte, 3'b000})));
`else
  logic unused_merge;
  assign unused_merge = ^{rt_val, merge_left};
  assign merge_v      = '0;
`endif

  always_comb begin
    load_data = '0;
    case (extr_word)
      EXTR_WORD:  load_data = word_v;
      EXTR_BYTE:  load_data = {{(DATA_BITS-8){extr_signed & byte_v[7]}}, byte_v};
      EXTR_HALF:  load_data = {{(DATA_BITS-16){extr_signed & half_v[15]}}, half_v};
      EXTR_MERGE: load_data = merge_v;
      default:    load_data = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: picks destination and data, registers the regfile write
// and keeps HI/LO. Optional LWL/LWR merge via WB_UNALIGNED_EN.
module wb_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_BITS   = 32,
  parameter int LINK_OFFSET = 4,
  parameter int RA_IDX      = RA_IDX_DEFAULT
) (
  input logic       clk,
  input logic       rst_n,
  wb_stage_if.slave bus
);

  logic                 accept;
  logic [4:0]           idx;
  logic [DATA_BITS-1:0] load_data;
  logic [DATA_BITS-1:0] hi_next;
  logic [DATA_BITS-1:0] lo_next;
  logic [DATA_BITS-1:0] lh_data;
  logic [DATA_BITS-1:0] link_data;
  logic [DATA_BITS-1:0] data;

  logic                 wb_valid_q;
  logic [4:0]           wb_idx_q;
  logic [DATA_BITS-1:0] wb_data_q;
  logic [DATA_BITS-1:0] hi_q;
  logic [DATA_BITS-1:0] lo_q;

  assign accept = bus.in_valid & ~bus.stall & ~bus.flush;
  assign idx    = bus.jal ? 5'(RA_IDX) : (bus.reg_dst ? bus.rd : bus.rt);

  // A same-beat HI/LO write is visible to a same-beat HI/LO read.
  assign hi_next = bus.hilo_we[1] ? bus.hi_in : hi_q;
  assign lo_next = bus.hilo_we[0] ? bus.lo_in : lo_q;

  assign link_data = bus.pc + DATA_BITS'(LINK_OFFSET);

  load_extract #(
    .DATA_BITS (DATA_BITS)
  ) u_load_extract (
    .extr_word   (bus.extr_word),
    .extr_signed (bus.extr_signed),
    .addr_byte   (bus.addr_byte),
    .mem_out     (bus.mem_out),
    .rt_val      (bus.rt_val),
    .merge_left  (bus.merge_left),
    .load_data   (load_data)
  );

  always_comb begin
    lh_data = '0;
    case (bus.lh_to_reg)
      LH_LO:   lh_data = lo_next;
      LH_HI:   lh_data = hi_next;
      default: lh_data = '0;
    endcase
  end

  always_comb begin
    data = bus.alu_out;
    if (bus.mem_to_reg)                data = load_data;
    else if (bus.lh_to_reg != LH_NONE) data = lh_data;
    else if (bus.link)                 data = link_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else if (bus.flush) begin
      wb_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      // Writes to r0 are dropped, but HI/LO still update on the beat.
      wb_valid_q <= accept && (idx != 5'd0);
      if (accept) begin
        wb_idx_q  <= idx;
        wb_data_q <= data;
        hi_q      <= hi_next;
        lo_q      <= lo_next;
      end
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_idx   = wb_idx_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized beats against a
// behavioural model; honours WB_UNALIGNED_EN for the merge cases.
module tb_wb_stage;
  import pipeline_pkg::*;

  localparam int W    = 32;
  localparam int LOFF = 8;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_BITS(W)) bus ();

  wb_stage #(
    .DATA_BITS   (W),
    .LINK_OFFSET (LOFF),
    .RA_IDX      (31)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit           m_valid = 1'b0;
  logic [4:0]   m_idx   = '0;
  logic [W-1:0] m_data  = '0;
  logic [W-1:0] m_hi    = '0;
  logic [W-1:0] m_lo    = '0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Byte-list view of a load: memory byte i of a big-endian word is bits 31-8i.
  function automatic logic [W-1:0] ref_load(input int ew, input bit sgn, input int ab,
                                            input logic [W-1:0] mem);
    logic [W-1:0] r;
    logic [7:0]   m [4];
    logic [7:0]   o [4];
    r = '0;
    case (ew)
      0: r = mem;
      1: begin
        r = (mem >> (8 * ab)) & 32'hFF;
        if (sgn && r[7]) r = r | 32'hFFFF_FF00;
      end
      2: begin
        r = (mem >> (16 * (ab / 2))) & 32'hFFFF;
        if (sgn && r[15]) r = r | 32'hFFFF_0000;
      end
      default: begin
`ifdef WB_UNALIGNED_EN
        for (int i = 0; i < 4; i++) begin
          m[i] = 8'(mem >> (24 - 8 * i));
          o[i] = 8'(bus.rt_val >> (24 - 8 * i));
        end
        if (bus.merge_left) begin
          for (int j = 0; j <= 3 - ab; j++) o[j] = m[ab + j];
        end else begin
          for (int j = 0; j <= ab; j++) o[3 - ab + j] = m[j];
        end
        r = {o[0], o[1], o[2], o[3]};
`else
        m[0] = '0;
        o[0] = '0;
        r = '0;
`endif
      end
    endcase
    return r;
  endfunction

  // Applies the stage rules to the inputs currently driven.
  task automatic model_edge();
    logic [W-1:0] hi_e, lo_e, d;
    int ix;
    if (bus.flush) begin
      m_valid = 1'b0;
    end else if (!bus.stall) begin
      if (!bus.in_valid) begin
        m_valid = 1'b0;
      end else begin
        hi_e = bus.hilo_we[1] ? bus.hi_in : m_hi;
        lo_e = bus.hilo_we[0] ? bus.lo_in : m_lo;
        ix   = bus.jal ? 31 : (bus.reg_dst ? int'(bus.rd) : int'(bus.rt));
        if (bus.mem_to_reg)              d = ref_load(int'(bus.extr_word), bus.extr_signed,
                                                      int'(bus.addr_byte), bus.mem_out);
        else if (bus.lh_to_reg == LH_LO)  d = lo_e;
        else if (bus.lh_to_reg == LH_HI)  d = hi_e;
        else if (bus.lh_to_reg == LH_BAD) d = '0;
        else if (bus.link)                d = bus.pc + W'(LOFF);
        else                              d = bus.alu_out;
        m_hi    = hi_e;
        m_lo    = lo_e;
        m_idx   = 5'(ix);
        m_data  = d;
        m_valid = (ix != 0);
      end
    end
    if (m_valid) exp_q.push_back(m_data);
  endtask

  task automatic compare_all(input string tag);
    logic [W-1:0] e;
    check({tag, ".valid"}, bus.wb_valid, m_valid);
    if (m_valid) begin
      e = exp_q.pop_front();
      check({tag, ".idx"}, bus.wb_idx, m_idx);
      check({tag, ".data"}, bus.wb_data, e);
    end
    check({tag, ".hi"}, bus.hi, m_hi);
    check({tag, ".lo"}, bus.lo, m_lo);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // driver tasks
  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.rt          = '0;
    bus.rd          = '0;
    bus.reg_dst     = 1'b0;
    bus.jal         = 1'b0;
    bus.link        = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.extr_signed = 1'b0;
    bus.extr_word   = EXTR_WORD;
    bus.lh_to_reg   = LH_NONE;
    bus.alu_out     = '0;
    bus.mem_out     = '0;
    bus.pc          = '0;
    bus.rt_val      = '0;
    bus.addr_byte   = '0;
    bus.merge_left  = 1'b0;
    bus.hilo_we     = '0;
    bus.hi_in       = '0;
    bus.lo_in       = '0;
  endtask

  task automatic alu_beat(input logic [4:0] dst, input logic [W-1:0] val);
    idle();
    bus.in_valid = 1'b1;
    bus.rt       = dst;
    bus.alu_out  = val;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, bus.wb_valid, 1'b0);
    check({tag, ".idx"},   bus.wb_idx,   5'd0);
    check({tag, ".data"},  bus.wb_data,  32'd0);
    check({tag, ".hi"},    bus.hi,       32'd0);
    check({tag, ".lo"},    bus.lo,       32'd0);
  endtask

  task automatic random_beat();
    idle();
    bus.in_valid    = ($urandom_range(0, 3) != 0);
    bus.stall       = ($urandom_range(0, 4) == 0);
    bus.flush       = ($urandom_range(0, 7) == 0);
    bus.rt          = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    bus.rd          = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    bus.reg_dst     = 1'($urandom_range(0, 1));
    bus.jal         = ($urandom_range(0, 7) == 0);
    bus.link        = 1'($urandom_range(0, 1));
    bus.mem_to_reg  = 1'($urandom_range(0, 1));
    bus.extr_signed = 1'($urandom_range(0, 1));
    bus.extr_word   = extr_e'(2'($urandom_range(0, 3)));
    bus.lh_to_reg   = ($urandom_range(0, 2) == 0) ? lh_e'(2'($urandom_range(1, 3))) : LH_NONE;
    bus.alu_out     = $urandom;
    bus.mem_out     = $urandom;
    bus.pc          = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                                  : $urandom;
    bus.rt_val      = $urandom;
    bus.addr_byte   = 2'($urandom_range(0, 3));
    bus.merge_left  = 1'($urandom_range(0, 1));
    bus.hilo_we     = 2'($urandom_range(0, 3));
    bus.hi_in       = $urandom;
    bus.lo_in       = $urandom;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // signed and unsigned byte load
    idle();
    bus.in_valid = 1'b1; bus.mem_to_reg = 1'b1; bus.rt = 5'd5;
    bus.extr_word = EXTR_BYTE; bus.mem_out = 32'h8070_60F0; bus.extr_signed = 1'b1;
    step("lb_signed");
    check("lb_signed.spec", bus.wb_data, 32'hFFFF_FFF0);
    bus.extr_signed = 1'b0;
    step("lb_unsigned");
    check("lb_unsigned.spec", bus.wb_data, 32'h0000_00F0);

    // signed halfword from the upper half
    bus.extr_word = EXTR_HALF; bus.addr_byte = 2'd2; bus.extr_signed = 1'b1;
    step("lh_signed");
    check("lh_signed.spec", bus.wb_data, 32'hFFFF_8070);

    // jal link write
    idle();
    bus.in_valid = 1'b1; bus.jal = 1'b1; bus.link = 1'b1; bus.pc = 32'h0040_0010;
    step("jal");
    check("jal.idx", bus.wb_idx, 5'd31);
    check("jal.data", bus.wb_data, 32'h0040_0018);
    check("jal.valid", bus.wb_valid, 1'b1);
    bus.pc = 32'hFFFF_FFFC;
    step("jal_wrap");
    check("jal_wrap.data", bus.wb_data, 32'h0000_0004);

    // HI write bypassed to a same-beat HI read
    idle();
    bus.in_valid = 1'b1; bus.rt = 5'd3; bus.hilo_we = 2'b10; bus.hi_in = 32'h1234;
    bus.lh_to_reg = LH_HI;
    step("hi_bypass");
    check("hi_bypass.data", bus.wb_data, 32'h1234);
    check("hi_bypass.hi", bus.hi, 32'h1234);
    bus.hilo_we = 2'b00; bus.lh_to_reg = LH_BAD;
    step("lh_bad");
    check("lh_bad.data", bus.wb_data, 32'h0);

    // stall freezes outputs, flush inside the stall clears valid
    alu_beat(5'd7, 32'hA5);
    step("pre_stall");
    bus.stall = 1'b1; bus.alu_out = 32'h5A; bus.hilo_we = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check("stall.frozen", bus.wb_data, 32'hA5);
    end
    bus.flush = 1'b1;
    step("stall_flush");
    check("stall_flush.valid", bus.wb_valid, 1'b0);

    // write to r0 is suppressed
    alu_beat(5'd0, 32'hDEAD);
    bus.reg_dst = 1'b1; bus.rd = 5'd0; bus.rt = 5'd4;
    step("r0");
    check("r0.valid", bus.wb_valid, 1'b0);

    // reset in the middle of a stall, then accept on the first edge
    alu_beat(5'd9, 32'h7777);
    bus.hilo_we = 2'b11; bus.hi_in = 32'h1111; bus.lo_in = 32'h2222;
    step("pre_rst");
    bus.stall = 1'b1;
    step("stall_rst");
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    m_valid = 1'b0; m_idx = '0; m_data = '0; m_hi = '0; m_lo = '0;
    exp_q.delete();
    #1 rst_n = 1'b1;
    alu_beat(5'd12, 32'hCAFE);
    step("post_rst");
    check("post_rst.data", bus.wb_data, 32'hCAFE);

    // unaligned merge
    idle();
    bus.in_valid = 1'b1; bus.mem_to_reg = 1'b1; bus.rt = 5'd8; bus.extr_word = EXTR_MERGE;
    bus.addr_byte = 2'd1; bus.merge_left = 1'b1;
    bus.mem_out = 32'h1122_3344; bus.rt_val = 32'hAABB_CCDD;
    step("lwl");
`ifdef WB_UNALIGNED_EN
    check("lwl.spec", bus.wb_data, 32'h2233_44DD);
    bus.merge_left = 1'b0;
    step("lwr");
    check("lwr.spec", bus.wb_data, 32'hAABB_1122);
`else
    check("merge_off.spec", bus.wb_data, 32'h0);
`endif

    // randomized beats
    for (int i = 0; i < 400; i++) begin
      random_beat();
      step("rand");
    end

    check("exp_q.drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
